// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Purpose  : RAW hazard stall / branch flush controller for a 5-stage MIPS
//             pipeline, with saturating stall and flush cycle counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int FORWARDING  = 1,
    parameter int WB_BYPASS   = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_regwrite,
    input  logic                  branch_taken,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  flush_ifid,
    output logic                  busy_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_cycles
);

    localparam int FC_W = $clog2(FLUSH_DEPTH + 1);

    localparam logic [0:0]      c_run    = 1'b0;
    localparam logic [0:0]      c_flush  = 1'b1;
    localparam logic [FC_W-1:0] c_reload = FC_W'(FLUSH_DEPTH - 1);
    localparam logic [FC_W-1:0] c_one    = FC_W'(1);
    localparam logic [FC_W-1:0] c_zero   = '0;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [REG_ADDR_W-1:0] c_r0 = '0;

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [FC_W-1:0] r_fcnt;
    logic [FC_W-1:0] w_next_fcnt;

    logic w_m_ex;
    logic w_m_mem;
    logic w_m_wb;
    logic w_haz_fwd;
    logic w_haz_nofwd;
    logic w_haz;

    // Register 0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic src_match(input logic [REG_ADDR_W-1:0] dest,
                                       input logic                  we);
        return we && (dest != c_r0) &&
               ((id_uses_rs && (id_rs == dest)) || (id_uses_rt && (id_rt == dest)));
    endfunction

    assign w_m_ex  = src_match(ex_dest,  ex_regwrite);
    assign w_m_mem = src_match(mem_dest, mem_regwrite);
    assign w_m_wb  = src_match(wb_dest,  wb_regwrite);

    assign w_haz_fwd   = id_valid && w_m_ex && ex_memread;
    assign w_haz_nofwd = id_valid && (w_m_ex || w_m_mem || (w_m_wb && (WB_BYPASS == 0)));
    assign w_haz       = (FORWARDING != 0) ? w_haz_fwd : w_haz_nofwd;

    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        flush_ifid   = 1'b0;
        w_next_state = r_state;
        w_next_fcnt  = r_fcnt;
        case (r_state)
            c_run: begin
                // A redirect squashes the instruction that would have been stalled.
                if (branch_taken) begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        w_next_state = c_flush;
                        w_next_fcnt  = c_reload;
                    end
                end else if (w_haz) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            c_flush: begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
                if (branch_taken) begin
                    w_next_fcnt = c_reload;
                end else if (r_fcnt == c_one) begin
                    w_next_state = c_run;
                    w_next_fcnt  = c_zero;
                end else begin
                    w_next_fcnt = r_fcnt - c_one;
                end
            end
            default: begin
                w_next_state = c_run;
                w_next_fcnt  = c_zero;
            end
        endcase
    end

    assign busy_flush = (r_state == c_flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_run;
            r_fcnt  <= c_zero;
        end else begin
            r_state <= w_next_state;
            r_fcnt  <= w_next_fcnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_pc && (stall_cycles != c_cnt_max)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_ifid && (flush_cycles != c_cnt_max)) begin
                flush_cycles <= flush_cycles + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_unit
//  Purpose  : Directed vector bench for hazard_ctrl_unit in three configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] ex_dest;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] mem_dest;
    logic       mem_regwrite;
    logic [4:0] wb_dest;
    logic       wb_regwrite;
    logic       branch_taken;

    // u_fwd: forwarding, 3-cycle flush
    logic        f_stall_pc, f_stall_ifid, f_bubble, f_flush, f_busy;
    logic [15:0] f_stall_cnt, f_flush_cnt;
    // u_nf: no forwarding, WB matches stall, 1-cycle flush, 2-bit counters
    logic        n_stall_pc, n_stall_ifid, n_bubble, n_flush, n_busy;
    logic [1:0]  n_stall_cnt, n_flush_cnt;
    // u_nfb: no forwarding, WB bypass
    logic        b_stall_pc, b_stall_ifid, b_bubble, b_flush, b_busy;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .FORWARDING(1), .WB_BYPASS(1), .FLUSH_DEPTH(3), .CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_dest(ex_dest),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dest(mem_dest),
        .mem_regwrite(mem_regwrite), .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .stall_pc(f_stall_pc), .stall_ifid(f_stall_ifid),
        .bubble_idex(f_bubble), .flush_ifid(f_flush), .busy_flush(f_busy),
        .stall_cycles(f_stall_cnt), .flush_cycles(f_flush_cnt));

    hazard_ctrl_unit #(.REG_ADDR_W(5), .FORWARDING(0), .WB_BYPASS(0), .FLUSH_DEPTH(1), .CNT_W(2)) u_nf (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_dest(ex_dest),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dest(mem_dest),
        .mem_regwrite(mem_regwrite), .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .stall_pc(n_stall_pc), .stall_ifid(n_stall_ifid),
        .bubble_idex(n_bubble), .flush_ifid(n_flush), .busy_flush(n_busy),
        .stall_cycles(n_stall_cnt), .flush_cycles(n_flush_cnt));

    hazard_ctrl_unit #(.REG_ADDR_W(5), .FORWARDING(0), .WB_BYPASS(1), .FLUSH_DEPTH(2), .CNT_W(16)) u_nfb (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_dest(ex_dest),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dest(mem_dest),
        .mem_regwrite(mem_regwrite), .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
        .branch_taken(branch_taken), .stall_pc(b_stall_pc), .stall_ifid(b_stall_ifid),
        .bubble_idex(b_bubble), .flush_ifid(b_flush), .busy_flush(b_busy),
        .stall_cycles(b_stall_cnt), .flush_cycles(b_flush_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] exd;
        logic       exw, exm;
        logic [4:0] memd;
        logic       memw;
        logic [4:0] wbd;
        logic       wbw;
        logic       e_fwd, e_nf, e_nfb;   // expected stall per configuration
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;
    int efs_fwd = 0;
    int efs_nf  = 0;
    int efs_nfb = 0;
    int eff_fwd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_dest = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_dest = '0; mem_regwrite = 1'b0; wb_dest = '0; wb_regwrite = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic drive_vec(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_uses_rs = t.urs; id_uses_rt = t.urt;
        ex_dest = t.exd; ex_regwrite = t.exw; ex_memread = t.exm;
        mem_dest = t.memd; mem_regwrite = t.memw; wb_dest = t.wbd; wb_regwrite = t.wbw;
    endtask

    // Drives branch_taken per cycle and checks u_fwd flush/busy against the masks.
    task automatic flush_seq(input string nm, input logic [7:0] bt, input logic [7:0] ef,
                             input logic [7:0] eb, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            branch_taken = bt[i];
            #4;
            chk($sformatf("%s_flush_c%0d", nm, i), f_flush, ef[i]);
            chk($sformatf("%s_busy_c%0d", nm, i), f_busy, eb[i]);
            chk($sformatf("%s_bubble_c%0d", nm, i), f_bubble, ef[i]);
            chk($sformatf("%s_stallpc_c%0d", nm, i), f_stall_pc, 1'b0);
            @(posedge clk);
            #1;
            if (ef[i]) eff_fwd++;
        end
        branch_taken = 1'b0;
        chk($sformatf("%s_flush_cnt", nm), f_flush_cnt, eff_fwd);
    endtask

    initial begin
        //           v  rs rt urs urt exd exw exm memd memw wbd wbw  fwd nf nfb
        vecs[0]  = '{1, 5, 0, 1, 0,  5, 1, 1,  0, 0,   0, 0,   1, 1, 1};
        vecs[1]  = '{1, 5, 0, 1, 0,  5, 1, 0,  0, 0,   0, 0,   0, 1, 1};
        vecs[2]  = '{1, 0, 0, 1, 0,  0, 1, 1,  0, 0,   0, 0,   0, 0, 0};
        vecs[3]  = '{1, 0, 7, 0, 1,  0, 0, 0,  0, 0,   7, 1,   0, 1, 0};
        vecs[4]  = '{1, 3, 0, 1, 0,  0, 0, 0,  3, 1,   0, 0,   0, 1, 1};
        vecs[5]  = '{0, 5, 0, 1, 0,  5, 1, 1,  0, 0,   0, 0,   0, 0, 0};
        vecs[6]  = '{1, 5, 0, 0, 0,  5, 1, 1,  0, 0,   0, 0,   0, 0, 0};
        vecs[7]  = '{1, 2, 9, 1, 1,  9, 1, 1,  0, 0,   0, 0,   1, 1, 1};
        vecs[8]  = '{1, 4, 6, 1, 1,  8, 1, 1, 10, 1,  11, 1,   0, 0, 0};
        vecs[9]  = '{1, 5, 0, 1, 0,  5, 0, 1,  0, 0,   0, 0,   0, 0, 0};
        vecs[10] = '{1,12, 0, 1, 0,  0, 0, 0,  0, 1,  12, 1,   0, 1, 0};

        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall_pc", f_stall_pc, 1'b0);
        chk("rst_flush", f_flush, 1'b0);
        chk("rst_busy", f_busy, 1'b0);
        chk("rst_stall_cnt", f_stall_cnt, 0);
        chk("rst_flush_cnt", f_flush_cnt, 0);
        reset = 1'b0;

        // Combinational hazard detection across the three configurations
        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            drive_vec(vecs[k]);
            #4;
            chk($sformatf("v%0d_fwd_stall_pc", k), f_stall_pc, vecs[k].e_fwd);
            chk($sformatf("v%0d_fwd_stall_ifid", k), f_stall_ifid, vecs[k].e_fwd);
            chk($sformatf("v%0d_fwd_bubble", k), f_bubble, vecs[k].e_fwd);
            chk($sformatf("v%0d_fwd_flush", k), f_flush, 1'b0);
            chk($sformatf("v%0d_nf_stall_pc", k), n_stall_pc, vecs[k].e_nf);
            chk($sformatf("v%0d_nf_bubble", k), n_bubble, vecs[k].e_nf);
            chk($sformatf("v%0d_nfb_stall_pc", k), b_stall_pc, vecs[k].e_nfb);
            chk($sformatf("v%0d_nfb_stall_ifid", k), b_stall_ifid, vecs[k].e_nfb);
            @(posedge clk);
            #1;
            if (vecs[k].e_fwd) efs_fwd++;
            if (vecs[k].e_nf && efs_nf < 3) efs_nf++;
            if (vecs[k].e_nfb) efs_nfb++;
            chk($sformatf("v%0d_fwd_stall_cnt", k), f_stall_cnt, efs_fwd);
            chk($sformatf("v%0d_nf_stall_cnt_sat", k), n_stall_cnt, efs_nf);
            chk($sformatf("v%0d_nfb_stall_cnt", k), b_stall_cnt, efs_nfb);
        end
        @(negedge clk);
        clear_inputs();

        // Single pulse: 3 flush cycles, busy on cycles 2-3
        flush_seq("flushA", 8'b0000_0001, 8'b0000_0111, 8'b0000_0110, 4);
        // Re-pulse on cycle 2 extends the window to 4 cycles
        flush_seq("flushB", 8'b0000_0011, 8'b0000_1111, 8'b0000_1110, 5);

        // Branch and load-use in the same cycle: redirect wins
        @(negedge clk);
        drive_vec(vecs[0]);
        branch_taken = 1'b1;
        #4;
        chk("br_haz_flush", f_flush, 1'b1);
        chk("br_haz_stall_pc", f_stall_pc, 1'b0);
        chk("br_haz_stall_ifid", f_stall_ifid, 1'b0);
        chk("br_haz_bubble", f_bubble, 1'b1);
        chk("br_haz_nf_flush", n_flush, 1'b1);
        chk("br_haz_nf_stall_pc", n_stall_pc, 1'b0);
        @(posedge clk);
        #1;
        eff_fwd++;
        chk("br_haz_stall_cnt", f_stall_cnt, efs_fwd);
        clear_inputs();
        flush_seq("br_tail", 8'b0000_0000, 8'b0000_0011, 8'b0000_0011, 3);

        // Asynchronous reset in cycle 2 of a flush
        @(negedge clk);
        branch_taken = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("pre_rst_busy", f_busy, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_busy", f_busy, 1'b0);
        chk("arst_flush", f_flush, 1'b0);
        chk("arst_bubble", f_bubble, 1'b0);
        chk("arst_flush_cnt", f_flush_cnt, 0);
        chk("arst_stall_cnt", f_stall_cnt, 0);
        chk("arst_nf_stall_cnt", n_stall_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            chk($sformatf("post_rst_flush_c%0d", i), f_flush, 1'b0);
            chk($sformatf("post_rst_busy_c%0d", i), f_busy, 1'b0);
            chk($sformatf("post_rst_stall_c%0d", i), f_stall_pc, 1'b0);
            chk($sformatf("post_rst_bubble_c%0d", i), f_bubble, 1'b0);
        end
        #2;
        chk("post_rst_flush_cnt", f_flush_cnt, 0);
        chk("post_rst_stall_cnt", f_stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
